traffic_ctrl_param: RTL and testbench

Parametrised two-road intersection controller. It is the next generation of the fixed-period main/cross light sequencer. Phase durations are counted in ticks of an external strobe rather than raw clocks and are set by parameters. The cross road is served only on demand, through a latched request. An optional all-red clearance phase can be compiled in. It sits between the tick prescaler and the lamp driver outputs.

---
 rtl/traffic_ctrl_param_pkg.sv | 50 +++++
 rtl/traffic_ctrl_param_if.sv | 25 ++
 rtl/traffic_ctrl_param_phase_timer.sv | 41 ++++
 rtl/traffic_ctrl_param.sv | 171 +++++++++++++++++
 tb/tb_traffic_ctrl_param.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_ctrl_param_pkg.sv
// traffic_pkg: shared definitions for the two-road intersection controller.
//   - State encoding localparams and the FSM state enum.
//   - Lamp codes (one-hot: green/yellow/red).
//   - lamps(): maps a state to its {main, cross} lamp pair.
// Optional feature macro: TRAFFIC_ALLRED_EN adds the ALLRED_A/ALLRED_B
// clearance states. Without it, those encodings are illegal.
package traffic_pkg;

  localparam logic [2:0] ST_MAIN_G   = 3'd0;
  localparam logic [2:0] ST_MAIN_Y   = 3'd1;
  localparam logic [2:0] ST_ALLRED_A = 3'd2;
  localparam logic [2:0] ST_CROSS_G  = 3'd3;
  localparam logic [2:0] ST_CROSS_Y  = 3'd4;
  localparam logic [2:0] ST_ALLRED_B = 3'd5;

  localparam logic [2:0] LT_GREEN  = 3'b001;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_RED    = 3'b100;

  typedef enum logic [2:0] {
    MAIN_G   = ST_MAIN_G,
    MAIN_Y   = ST_MAIN_Y,
`ifdef TRAFFIC_ALLRED_EN
    ALLRED_A = ST_ALLRED_A,
    ALLRED_B = ST_ALLRED_B,
`endif
    CROSS_G  = ST_CROSS_G,
    CROSS_Y  = ST_CROSS_Y
  } state_t;

  // Returns {main_lamps, cross_lamps}. Anything unrecognised shows red on
  // both roads, which is the safe display.
  function automatic logic [5:0] lamps(input state_t s);
    logic [5:0] l;
    l = {LT_RED, LT_RED};
    case (s)
      MAIN_G:   l = {LT_GREEN,  LT_RED};
      MAIN_Y:   l = {LT_YELLOW, LT_RED};
      CROSS_G:  l = {LT_RED,    LT_GREEN};
      CROSS_Y:  l = {LT_RED,    LT_YELLOW};
`ifdef TRAFFIC_ALLRED_EN
      ALLRED_A: l = {LT_RED,    LT_RED};
      ALLRED_B: l = {LT_RED,    LT_RED};
`endif
      default:  l = {LT_RED,    LT_RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_ctrl_param_if.sv
// traffic_ctrl_param_if: strobe/demand inputs and lamp/status outputs of
// the intersection controller.
//   iTick       one-cycle timing strobe
//   iCrossReq   cross-road demand (level or pulse)
//   main_st     main-road lamps, one-hot
//   cross_st    cross-road lamps, one-hot
//   oReqPending latched cross request not yet served
// Modports: master = environment driving the controller, slave = controller.
interface traffic_ctrl_param_if;
  logic       iTick;
  logic       iCrossReq;
  logic [2:0] main_st;
  logic [2:0] cross_st;
  logic       oReqPending;

  modport master (
    output iTick, iCrossReq,
    input  main_st, cross_st, oReqPending
  );

  modport slave (
    input  iTick, iCrossReq,
    output main_st, cross_st, oReqPending
  );
endinterface

// File: rtl/traffic_ctrl_param_phase_timer.sv
// phase_timer: CNT_W-bit loadable down counter used as the phase timer.
//   clk, rst_n  clock and asynchronous active-low reset (loads RESET_VAL)
//   load        load load_val this cycle (overrides tick)
//   load_val    value loaded on load
//   tick        decrement strobe; counter holds at zero
//   zero        counter currently equals zero
module phase_timer #(
  parameter int              CNT_W     = 8,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (tick && (count_reg != '0)) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= RESET_VAL;
    end else begin
      count_reg <= count_next;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param: two-road intersection controller. Phase durations
// are counted in iTick strobes; the cross road is served only on a latched
// request; main green is a minimum and holds until a request is pending.
//   iClk   clock, rising edge
//   iRstN  asynchronous active-low reset
//   bus    traffic_ctrl_param_if.slave (iTick, iCrossReq in;
//          main_st, cross_st, oReqPending out, all registered)
// Optional feature macro: TRAFFIC_ALLRED_EN inserts all-red clearance
// phases (ALLRED_TICKS long) after each yellow.
module traffic_ctrl_param
  import traffic_pkg::*;
#(
  parameter int MAIN_G_TICKS  = 15,
  parameter int YEL_TICKS     = 3,
  parameter int CROSS_G_TICKS = 10,
  parameter int ALLRED_TICKS  = 1,
  parameter int CNT_W         = 8
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  traffic_ctrl_param_if.slave  bus
);

  // Every duration must be at least one tick and D-1 must fit in CNT_W;
  // a bad configuration stops elaboration instead of truncating.
  localparam longint CAP = longint'(1) << CNT_W;
  localparam int DUR_CHK [4] = '{MAIN_G_TICKS, YEL_TICKS, CROSS_G_TICKS, ALLRED_TICKS};

  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_width
    $error("traffic_ctrl_param: CNT_W=%0d out of range", CNT_W);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_dur_chk
    if (DUR_CHK[gi] < 1 || longint'(DUR_CHK[gi]) > CAP) begin : g_bad
      $error("traffic_ctrl_param: duration %0d (=%0d) is zero or does not fit CNT_W",
             gi, DUR_CHK[gi]);
    end
  end

  localparam logic [CNT_W-1:0] MAIN_LD  = CNT_W'(MAIN_G_TICKS - 1);
  localparam logic [CNT_W-1:0] YEL_LD   = CNT_W'(YEL_TICKS - 1);
  localparam logic [CNT_W-1:0] CROSS_LD = CNT_W'(CROSS_G_TICKS - 1);
`ifdef TRAFFIC_ALLRED_EN
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
`endif

  state_t           state_reg;
  state_t           state_next;
  logic [2:0]       main_reg;
  logic [2:0]       main_next;
  logic [2:0]       cross_reg;
  logic [2:0]       cross_next;
  logic             req_reg;
  logic             req_next;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             timer_zero;
  logic             expire;
  logic             enter_cross;

  phase_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (MAIN_LD)
  ) u_timer (
    .clk      (iClk),
    .rst_n    (iRstN),
    .load     (load),
    .load_val (load_val),
    .tick     (bus.iTick),
    .zero     (timer_zero)
  );

  assign expire = bus.iTick & timer_zero;

  // Next-state: every transition reloads the timer with the new phase's
  // duration minus one. MAIN_G with no request just sits at zero.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    load_val   = MAIN_LD;
    case (state_reg)
      MAIN_G: begin
        if (expire && req_reg) begin
          state_next = MAIN_Y;
          load       = 1'b1;
          load_val   = YEL_LD;
        end
      end
      MAIN_Y: begin
        if (expire) begin
`ifdef TRAFFIC_ALLRED_EN
          state_next = ALLRED_A;
          load_val   = ALLRED_LD;
`else
          state_next = CROSS_G;
          load_val   = CROSS_LD;
`endif
          load       = 1'b1;
        end
      end
`ifdef TRAFFIC_ALLRED_EN
      ALLRED_A: begin
        if (expire) begin
          state_next = CROSS_G;
          load       = 1'b1;
          load_val   = CROSS_LD;
        end
      end
`endif
      CROSS_G: begin
        if (expire) begin
          state_next = CROSS_Y;
          load       = 1'b1;
          load_val   = YEL_LD;
        end
      end
      CROSS_Y: begin
        if (expire) begin
`ifdef TRAFFIC_ALLRED_EN
          state_next = ALLRED_B;
          load_val   = ALLRED_LD;
`else
          state_next = MAIN_G;
          load_val   = MAIN_LD;
`endif
          load       = 1'b1;
        end
      end
`ifdef TRAFFIC_ALLRED_EN
      ALLRED_B: begin
        if (expire) begin
          state_next = MAIN_G;
          load       = 1'b1;
          load_val   = MAIN_LD;
        end
      end
`endif
      default: begin
        state_next = MAIN_G;
        load       = 1'b1;
        load_val   = MAIN_LD;
      end
    endcase
  end

  // Lamps are registered from the next state so they change with it.
  assign {main_next, cross_next} = lamps(state_next);

  // A new demand on the CROSS_G entry edge survives the clear.
  assign enter_cross = (state_next == CROSS_G) && (state_reg != CROSS_G);
  assign req_next    = bus.iCrossReq | (req_reg & ~enter_cross);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_reg <= MAIN_G;
      main_reg  <= LT_GREEN;
      cross_reg <= LT_RED;
      req_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      cross_reg <= cross_next;
      req_reg   <= req_next;
    end
  end

  assign bus.main_st     = main_reg;
  assign bus.cross_st    = cross_reg;
  assign bus.oReqPending = req_reg;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Testbench for traffic_ctrl_param (default parameters). Works with or
// without TRAFFIC_ALLRED_EN. A phase-list model (phase index + ticks
// elapsed) predicts the outputs each cycle; directed scenarios add
// hand-computed phase lengths and periods.
module tb_traffic_ctrl_param;

`ifdef TRAFFIC_ALLRED_EN
  localparam bit ALLRED = 1'b1;
  localparam int NPH    = 6;
  localparam int CG_IDX = 3;
  localparam int DUR_T   [6] = '{15, 3, 1, 10, 3, 1};
  localparam int MAIN_L  [6] = '{1, 2, 4, 4, 4, 4};
  localparam int CROSS_L [6] = '{4, 4, 4, 1, 2, 4};
`else
  localparam bit ALLRED = 1'b0;
  localparam int NPH    = 4;
  localparam int CG_IDX = 2;
  localparam int DUR_T   [4] = '{15, 3, 10, 3};
  localparam int MAIN_L  [4] = '{1, 2, 4, 4};
  localparam int CROSS_L [4] = '{4, 4, 1, 2};
`endif

  logic iClk = 1'b0;
  logic iRstN;
  bit   check_en = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  traffic_ctrl_param_if bus ();

  traffic_ctrl_param dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .bus   (bus)
  );

  always #5 iClk = ~iClk;

  // ---------------- behavioural model ----------------
  int m_phase = 0;   // index into the phase list
  int m_el    = 0;   // ticks seen since entering the phase (saturates)
  bit m_pend  = 1'b0;
  int n_phase;
  int n_el;
  bit n_pend;

  always_comb begin
    n_phase = m_phase;
    n_el    = m_el;
    n_pend  = bus.iCrossReq | m_pend;
    if (bus.iTick) begin
      if (m_el >= DUR_T[m_phase] - 1) begin
        // D-th tick of the phase: leave it (main green needs a request)
        if (m_phase != 0 || m_pend) begin
          n_phase = (m_phase + 1) % NPH;
          n_el    = 0;
          if (n_phase == CG_IDX) n_pend = bus.iCrossReq;
        end
      end else begin
        n_el = m_el + 1;
      end
    end
  end

  always @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      m_phase <= 0;
      m_el    <= 0;
      m_pend  <= 1'b0;
    end else begin
      m_phase <= n_phase;
      m_el    <= n_el;
      m_pend  <= n_pend;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge iClk) begin
    if (check_en) begin
      check("main_st", 32'(bus.main_st), 32'(MAIN_L[m_phase]));
      check("cross_st", 32'(bus.cross_st), 32'(CROSS_L[m_phase]));
      check("req_pending", 32'(bus.oReqPending), 32'(m_pend));
    end
  end

  // ---------------- directed helpers ----------------
  logic [2:0] ms [300];
  logic [2:0] cs [300];
  logic       ps [300];

  task automatic next_cycle();
    @(negedge iClk);
    #1;
  endtask

  task automatic start_after_reset(input bit req0);
    bus.iTick     = 1'b1;
    bus.iCrossReq = req0;
    iRstN         = 1'b0;
    next_cycle();
    next_cycle();
    iRstN    = 1'b1;
    check_en = 1'b1;
  endtask

  // Sample k = outputs after k rising edges; mode 0 no request,
  // 1 request held, 2 single pulse seen by edge 40.
  task automatic record(input int n, input int tp, input int mode);
    ms[0] = bus.main_st;
    cs[0] = bus.cross_st;
    ps[0] = bus.oReqPending;
    for (int k = 1; k < n; k++) begin
      bus.iTick     = ((k % tp) == 0);
      bus.iCrossReq = (mode == 1) || (mode == 2 && k == 40);
      next_cycle();
      ms[k] = bus.main_st;
      cs[k] = bus.cross_st;
      ps[k] = bus.oReqPending;
    end
  endtask

  function automatic int find_main(input int from, input int n, input logic [2:0] v);
    for (int k = from; k < n; k++) if (ms[k] == v) return k;
    return -1;
  endfunction

  function automatic int find_cross(input int from, input int n, input logic [2:0] v);
    for (int k = from; k < n; k++) if (cs[k] == v) return k;
    return -1;
  endfunction

  initial begin
    int cnt;
    int cnt2;
    int cg;
    iRstN         = 1'b1;
    bus.iTick     = 1'b0;
    bus.iCrossReq = 1'b0;
    #3;

    // Scenario 1: request held from reset
    start_after_reset(1'b1);
    check("rst_main", 32'(bus.main_st), 32'h1);
    check("rst_cross", 32'(bus.cross_st), 32'h4);
    check("rst_pend", 32'(bus.oReqPending), 32'h0);
    record(70, 1, 1);
    check("mg_len", 32'(find_main(0, 70, 3'b010)), 32'd15);
    check("my_end", 32'(find_main(0, 70, 3'b100)), 32'd18);
    check("cg_start", 32'(find_cross(0, 70, 3'b001)), ALLRED ? 32'd19 : 32'd18);
    check("cy_start", 32'(find_cross(0, 70, 3'b010)), ALLRED ? 32'd29 : 32'd28);
    check("period", 32'(find_main(18, 70, 3'b001)), ALLRED ? 32'd33 : 32'd31);
    cnt = 0;
    for (int k = 0; k < 66; k++) if (ms[k] == 3'b100 && cs[k] == 3'b100) cnt++;
    check("both_red_cnt", 32'(cnt), ALLRED ? 32'd4 : 32'd0);
    $display("scenario held_req: main_green=%0d period=%0d both_red=%0d",
             find_main(0, 70, 3'b010), find_main(18, 70, 3'b001), cnt);

    // Scenario 2: no request for 200 cycles
    start_after_reset(1'b0);
    record(200, 1, 0);
    cnt = 0;
    cnt2 = 0;
    for (int k = 0; k < 200; k++) begin
      if (ms[k] == 3'b001) cnt++;
      if (ps[k]) cnt2++;
    end
    check("idle_green", 32'(cnt), 32'd200);
    check("idle_pend", 32'(cnt2), 32'd0);
    $display("scenario idle: green_cycles=%0d pending_cycles=%0d", cnt, cnt2);

    // Scenario 3: single pulse latched at edge 40
    start_after_reset(1'b0);
    record(80, 1, 2);
    check("pulse_pend39", 32'(ps[39]), 32'h0);
    check("pulse_pend40", 32'(ps[40]), 32'h1);
    check("pulse_main40", 32'(ms[40]), 32'h1);
    check("pulse_main41", 32'(ms[41]), 32'h2);
    cg = find_cross(0, 80, 3'b001);
    check("pulse_cg", 32'(cg), ALLRED ? 32'd45 : 32'd44);
    if (cg > 0) begin
      check("pulse_pend_cg", 32'(ps[cg]), 32'h0);
      check("pulse_pend_precg", 32'(ps[cg-1]), 32'h1);
    end
    $display("scenario pulse: cross_green_at=%0d", cg);

    // Scenario 4: tick every 4th cycle
    start_after_reset(1'b1);
    record(80, 4, 1);
    check("slow_mg_len", 32'(find_main(0, 80, 3'b010)), 32'd60);
    check("slow_my_end", 32'(find_main(0, 80, 3'b100)), 32'd72);
    $display("scenario slow_tick: main_green=%0d", find_main(0, 80, 3'b010));

    // Scenario 5: reset pulse during cross green
    start_after_reset(1'b1);
    record(25, 1, 1);
    check("pre_rst_cross", 32'(bus.cross_st), 32'h1);
    #1;
    iRstN = 1'b0;
    #1;
    check("async_main", 32'(bus.main_st), 32'h1);
    check("async_cross", 32'(bus.cross_st), 32'h4);
    check("async_pend", 32'(bus.oReqPending), 32'h0);
    next_cycle();
    iRstN = 1'b1;
    record(30, 1, 1);
    check("post_rst_mg_len", 32'(find_main(0, 30, 3'b010)), 32'd15);
    $display("scenario mid_reset: main_green_after=%0d", find_main(0, 30, 3'b010));

    // Scenario 6: random ticks, requests and occasional resets
    start_after_reset(1'b0);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        iRstN = 1'b0;
        next_cycle();
        iRstN = 1'b1;
      end else begin
        bus.iTick     = ($urandom_range(0, 2) != 0);
        bus.iCrossReq = ($urandom_range(0, 15) == 0);
        next_cycle();
      end
    end
    $display("scenario random: 3000 cycles");

    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
